// File: rtl/logic_axi4_lite_register_slave_pkg.sv
// Shared AXI4-Lite bus types and the address-window decode used by the
// register slave and the bus router.
package logic_axi4_lite_register_slave_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  // One target's byte-address window, both ends inclusive.
  typedef struct packed {
    logic [63:0] address_low;
    logic [63:0] address_high;
  } slave_t;

  typedef struct packed {
    resp_t       resp;
    logic [63:0] index;
  } decode_t;

  // Outside the window -> DECERR; inside but past the last register -> SLVERR.
  function automatic decode_t decode(input logic [63:0] address,
                                     input slave_t      slave,
                                     input int unsigned registers,
                                     input int unsigned offset_bits);
    decode_t     result;
    logic [63:0] offset;
    offset       = address - slave.address_low;
    result.resp  = RESP_OKAY;
    result.index = offset >> offset_bits;
    if (address < slave.address_low || address > slave.address_high) begin
      result.resp  = RESP_DECERR;
      result.index = '0;
    end else if (result.index >= 64'(registers)) begin
      result.resp = RESP_SLVERR;
    end
    return result;
  endfunction

endpackage

// File: rtl/logic_axi4_lite_register_slave_decoder.sv
// Combinational address decode: response code plus register index for one
// address channel.
module logic_axi4_lite_register_slave_decoder
  import logic_axi4_lite_register_slave_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_BYTES    = 4,
  parameter int unsigned REGISTERS     = 16,
  parameter int unsigned INDEX_WIDTH   = 4,
  parameter logic [63:0] ADDRESS_LOW   = 64'h0,
  parameter logic [63:0] ADDRESS_HIGH  = 64'hFFF
) (
  input  logic [ADDRESS_WIDTH-1:0] address,
  output resp_t                    resp,
  output logic [INDEX_WIDTH-1:0]   index
);

  localparam slave_t SLAVE = '{address_low: ADDRESS_LOW, address_high: ADDRESS_HIGH};

  decode_t result;
  logic    unused_index_bits;

  always_comb result = decode(64'(address), SLAVE, REGISTERS, $clog2(DATA_BYTES));

  // The index is only consumed on OKAY, where it is below REGISTERS and fits.
  assign resp              = result.resp;
  assign index             = result.index[INDEX_WIDTH-1:0];
  assign unused_index_bits = ^result.index[63:INDEX_WIDTH];

endmodule

// File: rtl/logic_axi4_lite_register_slave.sv
// AXI4-Lite register slave: independent AW/W holds, one outstanding B and
// one outstanding R, register file exported flat to the fabric.
module logic_axi4_lite_register_slave
  import logic_axi4_lite_register_slave_pkg::*;
#(
  parameter int unsigned             DATA_BYTES    = 4,
  parameter int unsigned             ADDRESS_WIDTH = 32,
  parameter int unsigned             REGISTERS     = 16,
  parameter logic [63:0]             ADDRESS_LOW   = 64'h0,
  parameter logic [63:0]             ADDRESS_HIGH  = 64'hFFF,
  parameter logic [8*DATA_BYTES-1:0] RESET_VALUE   = '0
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic                              awvalid,
  output logic                              awready,
  input  logic [ADDRESS_WIDTH-1:0]          awaddr,
  input  logic                              wvalid,
  output logic                              wready,
  input  logic [8*DATA_BYTES-1:0]           wdata,
  input  logic [DATA_BYTES-1:0]             wstrb,
  output logic                              bvalid,
  input  logic                              bready,
  output logic [1:0]                        bresp,
  input  logic                              arvalid,
  output logic                              arready,
  input  logic [ADDRESS_WIDTH-1:0]          araddr,
  output logic                              rvalid,
  input  logic                              rready,
  output logic [8*DATA_BYTES-1:0]           rdata,
  output logic [1:0]                        rresp,
  output logic [REGISTERS*8*DATA_BYTES-1:0] registers
);

  localparam int unsigned DATA_WIDTH  = 8 * DATA_BYTES;
  localparam int unsigned INDEX_WIDTH = (REGISTERS > 1) ? $clog2(REGISTERS) : 1;

  logic                     ready_en;
  logic                     aw_full, w_full, commit;
  logic [ADDRESS_WIDTH-1:0] aw_addr;
  logic [DATA_WIDTH-1:0]    w_data;
  logic [DATA_BYTES-1:0]    w_strb;
  resp_t                    aw_resp, ar_resp, bresp_q, rresp_q;
  logic [INDEX_WIDTH-1:0]   aw_index, ar_index;
  logic [DATA_WIDTH-1:0]    regs [REGISTERS];

  logic_axi4_lite_register_slave_decoder #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH), .DATA_BYTES(DATA_BYTES), .REGISTERS(REGISTERS),
    .INDEX_WIDTH(INDEX_WIDTH), .ADDRESS_LOW(ADDRESS_LOW), .ADDRESS_HIGH(ADDRESS_HIGH)
  ) u_aw_decoder (.address(aw_addr), .resp(aw_resp), .index(aw_index));

  logic_axi4_lite_register_slave_decoder #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH), .DATA_BYTES(DATA_BYTES), .REGISTERS(REGISTERS),
    .INDEX_WIDTH(INDEX_WIDTH), .ADDRESS_LOW(ADDRESS_LOW), .ADDRESS_HIGH(ADDRESS_HIGH)
  ) u_ar_decoder (.address(araddr), .resp(ar_resp), .index(ar_index));

  // ready_en keeps every ready low until the first edge after reset release.
  assign awready = ready_en & ~aw_full;
  assign wready  = ready_en & ~w_full;
  assign arready = ready_en & ~rvalid;
  assign commit  = aw_full & w_full & ~bvalid;
  assign bresp   = bresp_q;
  assign rresp   = rresp_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; this is what makes a same-edge read return the old data.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ready_en <= 1'b0;
      aw_full  <= 1'b0;
      aw_addr  <= '0;
      w_full   <= 1'b0;
      w_data   <= '0;
      w_strb   <= '0;
      bvalid   <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      ready_en <= 1'b1;
      if (commit) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
        bvalid  <= 1'b1;
        bresp_q <= aw_resp;
      end else begin
        if (awvalid && awready) begin
          aw_full <= 1'b1;
          aw_addr <= awaddr;
        end
        if (wvalid && wready) begin
          w_full <= 1'b1;
          w_data <= wdata;
          w_strb <= wstrb;
        end
        if (bvalid && bready) bvalid <= 1'b0;
      end
    end
  end

  // NOTE: the register file is built from flops, not a RAM macro, so giving
  // every word an asynchronous reset value is legal and intended.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < REGISTERS; i++) regs[i] <= RESET_VALUE;
    end else if (commit && aw_resp == RESP_OKAY) begin
      for (int b = 0; b < DATA_BYTES; b++) begin
        if (w_strb[b]) regs[aw_index][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp_q <= RESP_OKAY;
    end else if (arvalid && arready) begin
      rvalid  <= 1'b1;
      rresp_q <= ar_resp;
      rdata   <= (ar_resp == RESP_OKAY) ? regs[ar_index] : '0;
    end else if (rvalid && rready) begin
      rvalid <= 1'b0;
    end
  end

  for (genvar i = 0; i < REGISTERS; i++) begin : g_flat
    assign registers[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end

endmodule

// File: doc/logic_axi4_lite_register_slave.md
Name: logic_axi4_lite_register_slave

Overview:
- AXI4-Lite responder (slave end) for one bus address window.
- Decodes a transaction's address against its window: address_low..address_high inclusive, packed per the bus package slave_t.
- Serves an internal register file of REGISTERS words and returns OKAY, SLVERR or DECERR.
- Sits behind the AXI4-Lite bus router as the terminating target for control/status registers.

Parameters:
- DATA_BYTES, 4, bytes per data word (power of two; data width = 8*DATA_BYTES).
- ADDRESS_WIDTH, 32, awaddr/araddr width (<= 64).
- REGISTERS, 16, number of DATA_BYTES-wide registers (>= 1).
- ADDRESS_LOW, 64'h0, first byte address of the window (aligned to DATA_BYTES).
- ADDRESS_HIGH, 64'hFFF, last byte address of the window, inclusive.
- RESET_VALUE, 0, reset value of every register.

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous reset, active-high
- awvalid/awready  in/out  1  write address handshake
- awaddr  in  ADDRESS_WIDTH  write byte address
- wvalid/wready  in/out  1  write data handshake
- wdata  in  8*DATA_BYTES  write data
- wstrb  in  DATA_BYTES  byte enables
- bvalid/bready  out/in  1  write response handshake
- bresp  out  2  write response
- arvalid/arready  in/out  1  read address handshake
- araddr  in  ADDRESS_WIDTH  read byte address
- rvalid/rready  out/in  1  read data handshake
- rdata  out  8*DATA_BYTES  read data
- rresp  out  2  read response
- registers  out  REGISTERS*8*DATA_BYTES  flattened register contents, for the fabric

Behaviour:
- Reset (async assert, sync release):
  - All ready/valid outputs 0; bresp, rresp and rdata 0; all registers RESET_VALUE.
  - awready, wready and arready rise on the first aclk edge after release.
- Responses: OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11.
- Decode:
  - DECERR: addr < ADDRESS_LOW or addr > ADDRESS_HIGH.
  - Otherwise index = (addr-ADDRESS_LOW) >> log2(DATA_BYTES), with the low log2(DATA_BYTES) address bits ignored.
  - SLVERR: index >= REGISTERS.
  - OKAY: otherwise.
- Write path:
  - AW and W are accepted independently, in either order or the same cycle. Each is latched into its own holding register; awready/wready are low while that holding register is full.
  - Commit happens in the first cycle where both holds are full and bvalid=0:
    - Register update only on OKAY: bytes with wstrb[i]=1 take wdata, the rest are unchanged.
    - Both holds clear; bvalid=1 with bresp set on the next edge.
  - Latency: last of AW/W handshake at edge N -> bvalid high after edge N+1.
  - bvalid/bresp stay stable until bready; at most one outstanding B.
  - A held AW or W blocks further acceptance on that channel until commit; no reordering.
  - wstrb=0 with OKAY: no change, still OKAY.
- Read path:
  - arready = ~rvalid & ~areset-pending.
  - On the AR handshake at edge N, rvalid=1 after edge N with rdata/rresp captured. rdata = register on OKAY, 0 on SLVERR/DECERR.
  - rvalid/rdata/rresp stay stable until rready; then arready returns 1 on the following cycle.
- Read and write commit to the same register on the same edge: the read returns the pre-write value.
- Throughput: one read per 2 cycles and one write per 2 cycles, independent; the channels never stall each other.
- Reset mid-transaction: holds and outstanding B/R are dropped; no partial register update.

Decomposition:
- Bus package additions:
  - Response enum: OKAY, EXOKAY, SLVERR, DECERR.
  - A decode function (address, slave_t, registers) -> response/index, reused by the bus router.
- Sub-module logic_axi4_lite_register_slave_decoder: combinational decode, instantiated twice (AW hold, AR).

Test Plan:
- Reset release → readies 0 in the first cycle and 1 in the next; registers read 0; outputs 0.
- AW at cycle 2, W at cycle 5, addr=ADDRESS_LOW+8, wdata=32'hDEADBEEF, wstrb=4'hF → bvalid after edge 6, bresp=OKAY. A read of the same address returns 32'hDEADBEEF, rvalid one cycle after the AR handshake.
- Write 32'h11223344 with wstrb=4'b0101 over 32'hDEADBEEF → read returns 32'hDE22BE44.
- araddr=ADDRESS_HIGH+1 → rresp=DECERR, rdata=0. Write to index REGISTERS (still in window) → bresp=SLVERR and registers unchanged.
- bready held low 10 cycles after a write → bvalid/bresp stable, a second AW/W is latched but not committed, and it commits the cycle after bready. Same for rready with rdata stable.
- Write commit and read of the same index on the same edge → read returns the old value, and a subsequent read returns the new one. areset asserted mid-hold → no register change, all valids 0.
